// File: rtl/engine_match_reporter.sv
// Snapshots the engines' sticky match flags at end of payload and streams one
// {pkt_id, engine_id, last} record per set flag, lowest engine index first.
module engine_match_reporter #(
    parameter int NUM_ENGINES = 32,
    parameter int ID_W        = 5,
    parameter int PKT_ID_W    = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sod,
    input  logic                   en,
    input  logic                   eod,
    input  logic [PKT_ID_W-1:0]    pkt_id,
    input  logic [NUM_ENGINES-1:0] match_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ID_W-1:0]        m_engine_id,
    output logic [PKT_ID_W-1:0]    m_pkt_id,
    output logic                   m_last,
    output logic                   busy,
    output logic [15:0]            drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [NUM_ENGINES-1:0] FLAG_ONE = NUM_ENGINES'(1);
    localparam logic [AW:0]            PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        SCAN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKT_ID_W-1:0] pkt_id;
        logic [ID_W-1:0]     engine_id;
        logic                last;
    } rec_t;

    state_t                 state, state_nxt;
    logic [NUM_ENGINES-1:0] snap;
    logic [PKT_ID_W-1:0]    pkt_id_r;
    logic [ID_W-1:0]        scan_idx;
    logic                   scan_last;
    logic                   eod_hit;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AW:0]            wr_ptr, rd_ptr;
    rec_t                   mem [FIFO_DEPTH];
    rec_t                   head;

    // The engines own the start-of-data pulse; this block only needs eod.
    logic unused_sod;
    assign unused_sod = sod;

    assign eod_hit = eod & en;

    // Lowest set flag wins: iterate downward so the last hit is the lowest index.
    always_comb begin
        scan_idx = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (snap[i]) scan_idx = ID_W'(i);
        end
    end

    assign scan_last = ((snap & (snap - FLAG_ONE)) == '0);

    // FSM state register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: if (eod_hit) state_nxt = CAPT;
            CAPT: state_nxt = SCAN;
            SCAN: begin
                if (snap == '0) begin
                    state_nxt = IDLE;
                end else if (!fifo_full || pop) begin
                    push = 1'b1;
                    if (scan_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flags settle one clock after the final en, hence sampling in CAPT.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap     <= '0;
            pkt_id_r <= '0;
        end else begin
            if (state == IDLE && eod_hit) pkt_id_r <= pkt_id;
            if (state == CAPT)            snap <= match_in;
            else if (push)                snap <= snap & ~(FLAG_ONE << scan_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (state != IDLE && eod_hit && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

    // NOTE: the record storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{pkt_id: pkt_id_r, engine_id: scan_idx, last: scan_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Extra pointer MSB separates a full ring from an empty one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = m_valid & m_ready;

    assign head        = mem[rd_ptr[AW-1:0]];
    assign m_valid     = !fifo_empty;
    assign m_engine_id = head.engine_id;
    assign m_pkt_id    = head.pkt_id;
    assign m_last      = head.last;
    assign busy        = (state != IDLE);

endmodule
